// File: rtl/dtpu_infifo_adapter_pkg.sv
// Shared dtpu definitions: precision encodings, input-FIFO defaults and the
// input-FIFO control state encoding.
package dtpu_infifo_adapter_pkg;

  // Operand precision selector used across the dtpu datapath.
  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_FP16  = 2'd2,
    PREC_FP32  = 2'd3
  } dtpu_prec_e;

  localparam int unsigned DTPU_DATA_WIDTH   = 64;
  localparam int unsigned DTPU_INFIFO_DEPTH = 16;

  // Occupancy class of the input FIFO.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } infifo_state_e;

endpackage

// File: rtl/dtpu_infifo_adapter_if.sv
// Stream-in / FIFO-out bundle of the dtpu input adapter.
//   s_axis_*        : AXI-Stream slave side (producer -> adapter)
//   infifo_*        : first-word-fall-through pop side (adapter <-> dtpu_core)
// slave modport is the adapter view, master modport the surrounding logic.
interface dtpu_infifo_adapter_if
  import dtpu_infifo_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DTPU_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] infifo_dout;
  logic                  infifo_read;
  logic                  infifo_is_empty;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, infifo_read,
    output s_axis_tready, infifo_dout, infifo_is_empty
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, infifo_read,
    input  s_axis_tready, infifo_dout, infifo_is_empty
  );
endinterface

// File: rtl/dtpu_sync_fifo_fwft.sv
// Storage of the input FIFO: memory array plus wrapping read/write pointers.
// Occupancy tracking lives in the wrapper; writes/reads here are unqualified.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous pointer clear
//   wr_en_i    : write wr_data_i at the write pointer
//   rd_en_i    : advance the read pointer
//   rd_data_c  : word at the read pointer (fall-through, combinational)
module dtpu_sync_fifo_fwft #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Array contents need no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
endmodule

// File: rtl/dtpu_infifo_adapter.sv
// AXI-Stream to first-word-fall-through FIFO adapter feeding dtpu_core.
//   clk, aresetn  : clock, async active-low reset
//   flush         : synchronous clear of contents, level and frames_done
//   err_clear     : synchronous clear of err_underflow
//   bus (slave)   : s_axis_* stream in, infifo_* pop side out
//   level         : stored word count
//   frames_done   : popped words that carried tlast (wraps at 16 bits)
//   err_underflow : sticky, pop requested while empty
module dtpu_infifo_adapter
  import dtpu_infifo_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DTPU_DATA_WIDTH,
  parameter int unsigned DEPTH      = DTPU_INFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   flush,
  input  logic                   err_clear,
  dtpu_infifo_adapter_if.slave   bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            frames_done,
  output logic                   err_underflow
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  infifo_state_e   state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     frames_q, frames_d;
  logic            err_q, err_d;
  logic            tready_q, tready_d;
  logic            empty_q, empty_d;
  logic            push, pop, head_last;
  logic [DATA_WIDTH:0] head;

  // tready is registered, so push never depends on this cycle's pop.
  assign push = bus.s_axis_tvalid & tready_q;
  assign pop  = bus.infifo_read & (state_q != ST_EMPTY);

  // Each entry keeps tlast in its MSB so frame counting follows the pop.
  dtpu_sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (aresetn),
    .clr_i     (flush),
    .wr_en_i   (push & ~flush),
    .wr_data_i ({bus.s_axis_tlast, bus.s_axis_tdata}),
    .rd_en_i   (pop & ~flush),
    .rd_data_c (head)
  );

  assign head_last = head[DATA_WIDTH];

  // State and status registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_EMPTY;
      level_q  <= '0;
      frames_q <= '0;
      err_q    <= 1'b0;
      tready_q <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      frames_q <= frames_d;
      err_q    <= err_d;
      tready_q <= tready_d;
      empty_q  <= empty_d;
    end
  end

  // Next-state, occupancy, frame and error logic.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    frames_d = frames_q;
    err_d    = err_q;

    // Set wins over a simultaneous clear; flush leaves the flag alone.
    if (err_clear) err_d = 1'b0;
    if (bus.infifo_read && (state_q == ST_EMPTY)) err_d = 1'b1;

    if (flush) begin
      state_d  = ST_EMPTY;
      level_d  = '0;
      frames_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      if (pop && head_last) frames_d = frames_q + 16'd1;

      case (state_q)
        ST_EMPTY: begin
          if (push) state_d = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && (level_q == LW'(DEPTH - 1))) state_d = ST_FULL;
          else if (pop && !push && (level_q == LW'(1)))   state_d = ST_EMPTY;
        end
        ST_FULL: begin
          if (pop) state_d = ST_PARTIAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    tready_d = (level_d != LW'(DEPTH));
    empty_d  = (state_d == ST_EMPTY);
  end

  assign bus.s_axis_tready   = tready_q;
  assign bus.infifo_is_empty = empty_q;
  assign bus.infifo_dout     = head[DATA_WIDTH-1:0];
  assign level               = level_q;
  assign frames_done         = frames_q;
  assign err_underflow       = err_q;
endmodule

// File: tb/tb_dtpu_infifo_adapter.sv
// Self-checking bench for dtpu_infifo_adapter: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_dtpu_infifo_adapter;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        err_clear;
  logic [4:0]  level;
  logic [15:0] frames_done;
  logic        err_underflow;

  dtpu_infifo_adapter_if #(.DATA_WIDTH(DW)) bus ();

  dtpu_infifo_adapter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .flush         (flush),
    .err_clear     (err_clear),
    .bus           (bus),
    .level         (level),
    .frames_done   (frames_done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  string phase = "init";

  // Reference model: stored words in arrival order as {tlast, data}.
  logic [DW:0] mq [$];
  int unsigned m_frames;
  bit          m_err;
  bit          m_tready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level", 64'(level), 64'(mq.size()));
    check("is_empty", 64'(bus.infifo_is_empty), 64'(mq.size() == 0));
    check("tready", 64'(bus.s_axis_tready), 64'(m_tready));
    check("frames_done", 64'(frames_done), 64'(m_frames[15:0]));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
    if (mq.size() != 0) check("dout", bus.infifo_dout, mq[0][DW-1:0]);
  endtask

  task automatic model_reset();
    mq.delete();
    m_frames = 0;
    m_err    = 1'b0;
    m_tready = 1'b0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic cycle();
    bit          push, pop;
    logic [DW:0] w;
    @(posedge clk);
    if (aresetn) begin
      push = bus.s_axis_tvalid && m_tready;
      pop  = bus.infifo_read && (mq.size() != 0);
      if (bus.infifo_read && (mq.size() == 0)) m_err = 1'b1;
      else if (err_clear)                      m_err = 1'b0;
      if (flush) begin
        mq.delete();
        m_frames = 0;
      end else begin
        if (pop) begin
          w = mq.pop_front();
          if (w[DW]) m_frames = (m_frames + 1) & 32'hFFFF;
        end
        if (push) mq.push_back({bus.s_axis_tlast, bus.s_axis_tdata});
      end
      m_tready = (mq.size() != DEPTH);
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.infifo_read   = 1'b0;
    flush             = 1'b0;
    err_clear         = 1'b0;
  endtask

  // Assert reset (outputs must follow at once), hold, then release.
  task automatic apply_reset();
    aresetn = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_empty", 64'(bus.infifo_is_empty), 64'd1);
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();
    check("release_tready", 64'(bus.s_axis_tready), 64'd1);
  endtask

  task automatic push_n(input int n);
    bus.infifo_read   = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.s_axis_tdata = {$urandom, $urandom};
      bus.s_axis_tlast = ($urandom_range(0, 3) == 0);
      cycle();
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.s_axis_tvalid = 1'b0;
    bus.infifo_read   = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    bus.infifo_read = 1'b0;
  endtask

  initial begin
    bus.s_axis_tdata = '0;
    idle();
    model_reset();
    aresetn = 1'b1;
    #2;

    phase = "reset";
    apply_reset();

    phase = "three_words";
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_axis_tdata = 64'(8'h11 * (i + 1));
      bus.s_axis_tlast = (i == 2);
      cycle();
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check("dout0", bus.infifo_dout, 64'h11);
    bus.infifo_read = 1'b1;
    cycle();
    check("dout1", bus.infifo_dout, 64'h22);
    cycle();
    check("dout2", bus.infifo_dout, 64'h33);
    cycle();
    bus.infifo_read = 1'b0;
    check("frames1", 64'(frames_done), 64'd1);
    check("empty_after", 64'(bus.infifo_is_empty), 64'd1);

    phase = "fill";
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.s_axis_tdata = {$urandom, $urandom};
      bus.s_axis_tlast = 1'b0;
      cycle();
    end
    check("full_level", 64'(level), 64'd16);
    check("full_tready", 64'(bus.s_axis_tready), 64'd0);
    bus.s_axis_tdata = 64'hDEAD_BEEF;
    cycle();
    check("no_17th", 64'(level), 64'd16);
    bus.s_axis_tvalid = 1'b0;
    bus.infifo_read   = 1'b1;
    cycle();
    bus.infifo_read = 1'b0;
    check("tready_back", 64'(bus.s_axis_tready), 64'd1);
    check("level15", 64'(level), 64'd15);
    pop_n(15);

    phase = "steady8";
    push_n(8);
    bus.s_axis_tvalid = 1'b1;
    bus.infifo_read   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.s_axis_tdata = {$urandom, $urandom};
      bus.s_axis_tlast = ($urandom_range(0, 3) == 0);
      cycle();
      check("level8", 64'(level), 64'd8);
    end
    pop_n(8);

    phase = "underflow";
    bus.infifo_read = 1'b1;
    cycle();
    check("err_set", 64'(err_underflow), 64'd1);
    check("level0", 64'(level), 64'd0);
    err_clear = 1'b1;
    cycle();
    check("set_beats_clear", 64'(err_underflow), 64'd1);
    bus.infifo_read = 1'b0;
    cycle();
    check("err_cleared", 64'(err_underflow), 64'd0);
    err_clear = 1'b0;

    phase = "flush";
    push_n(5);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    bus.infifo_read   = 1'b1;
    cycle();
    bus.infifo_read = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_empty", 64'(bus.infifo_is_empty), 64'd1);
    check("flush_frames", 64'(frames_done), 64'd0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      bit fill_bias;
      fill_bias         = ((i / 60) % 2) == 0;
      bus.s_axis_tvalid = fill_bias ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      bus.infifo_read   = fill_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      bus.s_axis_tdata  = {$urandom, $urandom};
      bus.s_axis_tlast  = ($urandom_range(0, 2) == 0);
      flush             = ($urandom_range(0, 99) == 0);
      err_clear         = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();

    phase = "async_reset";
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push_n(6);
    check("pre_reset_level", 64'(level), 64'd6);
    #2;
    apply_reset();
    check("post_reset_level", 64'(level), 64'd0);

    phase = "after_reset";
    push_n(2);
    pop_n(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
